csr_unit_wb: RTL

WB-stage control/status register file for the dual-issue core. Consumes the WB-side CSR write and exception-commit strobes from the CSR pipeline register. Holds the architectural CSRs, the 64-bit stable counter and the countdown timer. Supplies the combinational CSR read port, redirect targets, rdcnt values and the pending-interrupt request back to EX/MEM.

---
 rtl/csr_unit_wb.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/csr_unit_wb.sv
// WB-stage CSR file: architectural CSRs, stable counter and countdown timer,
// with a combinational read port, redirect targets and the interrupt request.
module csr_unit_wb #(
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wb_stall,
    input  logic [7:0]  hw_int,
    input  logic [13:0] csr_raddr,
    output logic [31:0] csr_rdata,
    input  logic [13:0] WB_csr_waddr,
    input  logic [31:0] WB_csr_we,
    input  logic [31:0] WB_csr_wdata,
    input  logic [6:0]  WB_ecode_in,
    input  logic        WB_ecode_we,
    input  logic [31:0] WB_badv_in,
    input  logic        WB_badv_we,
    input  logic [31:0] WB_era_in,
    input  logic        WB_era_we,
    input  logic        WB_store_state,
    input  logic        WB_restore_state,
    output logic        MEM_interrupt,
    output logic [31:0] csr_eentry,
    output logic [31:0] csr_era,
    output logic [63:0] EX_rdcntv,
    output logic [31:0] EX_rdcntid
);

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 13;

    localparam logic [AW-1:0] A_CRMD   = AW'(14'h00);
    localparam logic [AW-1:0] A_PRMD   = AW'(14'h01);
    localparam logic [AW-1:0] A_ECFG   = AW'(14'h04);
    localparam logic [AW-1:0] A_ESTAT  = AW'(14'h05);
    localparam logic [AW-1:0] A_ERA    = AW'(14'h06);
    localparam logic [AW-1:0] A_BADV   = AW'(14'h07);
    localparam logic [AW-1:0] A_EENTRY = AW'(14'h0C);
    localparam logic [AW-1:0] A_SAVE0  = AW'(14'h30);
    localparam logic [AW-1:0] A_SAVE1  = AW'(14'h31);
    localparam logic [AW-1:0] A_SAVE2  = AW'(14'h32);
    localparam logic [AW-1:0] A_SAVE3  = AW'(14'h33);
    localparam logic [AW-1:0] A_TID    = AW'(14'h40);
    localparam logic [AW-1:0] A_TCFG   = AW'(14'h41);
    localparam logic [AW-1:0] A_TVAL   = AW'(14'h42);
    localparam logic [AW-1:0] A_TICLR  = AW'(14'h44);

    localparam logic [IW-1:0] ECFG_MASK = IW'(13'h1BFF);

    logic [1:0]    crmd_plv;
    logic          crmd_ie;
    logic [1:0]    prmd_pplv;
    logic          prmd_pie;
    logic [IW-1:0] ecfg;
    logic [1:0]    estat_sw;
    logic [7:0]    estat_hw;
    logic          estat_ti;
    logic [5:0]    estat_ecode;
    logic          estat_esub;
    logic [DW-1:0] era;
    logic [DW-1:0] badv;
    logic [25:0]   eentry;
    logic [DW-1:0] save [4];
    logic [DW-1:0] tid;
    logic [DW-1:0] tcfg;
    logic [DW-1:0] tval;
    logic          armed;
    logic [63:0]   cnt;

    logic [DW-1:0] crmd_v, prmd_v, ecfg_v, estat_v, eentry_v;
    logic [IW-1:0] is_v;
    logic [DW-1:0] sw_old, sw_val;
    logic          sw_we, tcfg_wr, ticlr_clr, timer_fire;

    assign crmd_v   = {28'h0, 1'b1, crmd_ie, crmd_plv};
    assign prmd_v   = {29'h0, prmd_pie, prmd_pplv};
    assign ecfg_v   = {19'h0, ecfg};
    assign is_v     = {1'b0, estat_ti, 1'b0, estat_hw, estat_sw};
    assign estat_v  = {1'b0, 8'h0, estat_esub, estat_ecode, 3'b0, is_v};
    assign eentry_v = {eentry, 6'b0};

    function automatic logic [DW-1:0] csr_read(input logic [AW-1:0] a);
        case (a)
            A_CRMD:   return crmd_v;
            A_PRMD:   return prmd_v;
            A_ECFG:   return ecfg_v;
            A_ESTAT:  return estat_v;
            A_ERA:    return era;
            A_BADV:   return badv;
            A_EENTRY: return eentry_v;
            A_SAVE0:  return save[0];
            A_SAVE1:  return save[1];
            A_SAVE2:  return save[2];
            A_SAVE3:  return save[3];
            A_TID:    return tid;
            A_TCFG:   return tcfg;
            A_TVAL:   return tval;
            default:  return DW'(0);
        endcase
    endfunction

    // Bit-masked write merges into the old value of the addressed register.
    assign sw_old     = csr_read(WB_csr_waddr);
    assign sw_val     = (sw_old & ~WB_csr_we) | (WB_csr_wdata & WB_csr_we);
    assign sw_we      = !wb_stall && (WB_csr_we != DW'(0));
    assign tcfg_wr    = sw_we && (WB_csr_waddr == A_TCFG);
    assign ticlr_clr  = sw_we && (WB_csr_waddr == A_TICLR) && sw_val[0];
    assign timer_fire = !tcfg_wr && tcfg[0] && armed && (tval == DW'(0));

    assign csr_rdata     = csr_read(csr_raddr);
    assign csr_eentry    = eentry_v;
    assign csr_era       = era;
    assign EX_rdcntv     = cnt;
    assign EX_rdcntid    = tid;
    assign MEM_interrupt = crmd_ie & (|(is_v & ecfg));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crmd_plv    <= 2'b0;
            crmd_ie     <= 1'b0;
            prmd_pplv   <= 2'b0;
            prmd_pie    <= 1'b0;
            ecfg        <= IW'(0);
            estat_sw    <= 2'b0;
            estat_hw    <= 8'h0;
            estat_ti    <= 1'b0;
            estat_ecode <= 6'h0;
            estat_esub  <= 1'b0;
            era         <= DW'(0);
            badv        <= DW'(0);
            eentry      <= 26'h0;
            for (int i = 0; i < 4; i++) save[i] <= DW'(0);
            tid         <= TID_RESET;
            tcfg        <= DW'(0);
            tval        <= DW'(0);
            armed       <= 1'b0;
            cnt         <= 64'h0;
        end else begin
            cnt      <= cnt + 64'd1;
            estat_hw <= hw_int;

            if (sw_we) begin
                case (WB_csr_waddr)
                    A_CRMD:   {crmd_ie, crmd_plv}   <= sw_val[2:0];
                    A_PRMD:   {prmd_pie, prmd_pplv} <= sw_val[2:0];
                    A_ECFG:   ecfg     <= sw_val[IW-1:0] & ECFG_MASK;
                    A_ESTAT:  estat_sw <= sw_val[1:0];
                    A_ERA:    era      <= sw_val;
                    A_BADV:   badv     <= sw_val;
                    A_EENTRY: eentry   <= sw_val[31:6];
                    A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3:
                              save[WB_csr_waddr[1:0]] <= sw_val;
                    A_TID:    tid      <= sw_val;
                    A_TCFG:   tcfg     <= sw_val;
                    default:  ;
                endcase
            end

            // Exception strobes come after software writes so they win on conflicts.
            if (!wb_stall) begin
                if (WB_restore_state) begin
                    crmd_plv <= prmd_pplv;
                    crmd_ie  <= prmd_pie;
                end
                if (WB_store_state) begin
                    prmd_pplv <= crmd_plv;
                    prmd_pie  <= crmd_ie;
                    crmd_plv  <= 2'b0;
                    crmd_ie   <= 1'b0;
                end
                if (WB_ecode_we) begin
                    estat_ecode <= WB_ecode_in[5:0];
                    estat_esub  <= WB_ecode_in[6];
                end
                if (WB_era_we)  era  <= WB_era_in;
                if (WB_badv_we) badv <= WB_badv_in;
            end

            if (tcfg_wr) begin
                tval  <= {WB_csr_wdata[31:2], 2'b00};
                armed <= WB_csr_wdata[0];
            end else if (tcfg[0] && armed) begin
                if (tval != DW'(0))  tval  <= tval - DW'(1);
                else if (tcfg[1])    tval  <= {tcfg[31:2], 2'b00};
                else                 armed <= 1'b0;
            end

            if (timer_fire)     estat_ti <= 1'b1;
            else if (ticlr_clr) estat_ti <= 1'b0;
        end
    end

endmodule
